// File: rtl/div_pkg.sv
// Shared definitions for the repeated-subtraction divider: state encoding
// and default operand width.
package div_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_SUB    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/div_by_sub_dp.sv
// Divider datapath: dividend/divisor capture, running remainder and quotient,
// subtractor, full-width comparator and divisor zero detect.
module div_by_sub_dp
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             clear,
  input  logic             sub_en,
  input  logic             inc_en,
  input  logic             set_dz,
  output logic             ge,
  output logic             bzero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dz
);

  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] r_reg, r_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             dz_reg, dz_next;
  logic [WIDTH:0]   nz_chain;

  // OR-reduce the divisor bit by bit; nz_chain[WIDTH] is set if any bit is 1.
  assign nz_chain[0] = 1'b0;
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_nz
      assign nz_chain[gi+1] = nz_chain[gi] | b_reg[gi];
    end
  endgenerate

  assign bzero = ~nz_chain[WIDTH];
  assign ge    = (r_reg >= b_reg);

  always_comb begin
    a_next  = a_reg;
    b_next  = b_reg;
    r_next  = r_reg;
    q_next  = q_reg;
    dz_next = dz_reg;
    if (load_a) a_next = data_in;
    if (load_b) b_next = data_in;
    if (clear) begin
      r_next  = a_reg;
      q_next  = '0;
      dz_next = 1'b0;
    end else if (set_dz) begin
      q_next  = '1;
      dz_next = 1'b1;
    end else begin
      if (sub_en) r_next = r_reg - b_reg;
      if (inc_en) q_next = q_reg + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      r_reg  <= '0;
      q_reg  <= '0;
      dz_reg <= 1'b0;
    end else begin
      a_reg  <= a_next;
      b_reg  <= b_next;
      r_reg  <= r_next;
      q_reg  <= q_next;
      dz_reg <= dz_next;
    end
  end

  assign quotient  = q_reg;
  assign remainder = r_reg;
  assign dz        = dz_reg;

endmodule

// File: rtl/div_by_sub.sv
// Sequential unsigned divider by repeated subtraction. The FSM here is the
// controller; it strobes the datapath and reacts to its ge/bzero status.
module div_by_sub
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  state_t state_reg, state_next;

  logic load_a, load_b, clear, sub_en, inc_en, set_dz;
  logic ge, bzero, dz;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load_a     = 1'b0;
    load_b     = 1'b0;
    clear      = 1'b0;
    sub_en     = 1'b0;
    inc_en     = 1'b0;
    set_dz     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_LOAD_A;
      end
      ST_LOAD_A: begin
        load_a     = 1'b1;
        state_next = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        load_b     = 1'b1;
        clear      = 1'b1;
        state_next = ST_SUB;
      end
      ST_SUB: begin
        if (bzero) begin
          set_dz     = 1'b1;
          state_next = ST_DONE;
        end else if (ge) begin
          sub_en = 1'b1;
          inc_en = 1'b1;
        end else begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // Holding start keeps us here; a fresh request needs a low cycle first.
        if (!start) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  div_by_sub_dp #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .load_a    (load_a),
    .load_b    (load_b),
    .clear     (clear),
    .sub_en    (sub_en),
    .inc_en    (inc_en),
    .set_dz    (set_dz),
    .ge        (ge),
    .bzero     (bzero),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz)
  );

  assign busy        = (state_reg == ST_LOAD_A) || (state_reg == ST_LOAD_B) ||
                       (state_reg == ST_SUB);
  assign done        = (state_reg == ST_DONE);
  assign div_by_zero = dz && (state_reg == ST_DONE);

endmodule

// File: tb/tb_div_by_sub.sv
// Self-checking bench for div_by_sub: directed cases plus random operands,
// checked against plain integer division in the bench.
module tb_div_by_sub;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] data_in;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_by_sub #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .data_in     (data_in),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: drop start after E0; 1: hold start high throughout and past done;
  // 2: toggle start every cycle while busy.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input string tag, input int mode);
    logic [W-1:0] exp_q, exp_r;
    logic         exp_dz;
    int           exp_lat, cycles;
    logic         both_seen;
    if (b == 0) begin
      exp_q = '1; exp_r = a; exp_dz = 1'b1; exp_lat = 3;
    end else begin
      exp_q = a / b; exp_r = a % b; exp_dz = 1'b0; exp_lat = int'(exp_q) + 3;
    end
    start = 1'b1;
    tick();                                   // E0
    data_in = a;
    start = (mode == 1);
    tick();                                   // E1
    data_in = b;
    tick();                                   // E2
    cycles = 2;
    both_seen = 1'b0;
    while (!done && cycles < exp_lat + 20) begin
      data_in = W'($urandom);
      if (mode == 2) start = ~start;
      tick();
      cycles++;
      if (busy && done) both_seen = 1'b1;
    end
    check({tag, " latency"}, cycles, exp_lat);
    check({tag, " quotient"}, quotient, exp_q);
    check({tag, " remainder"}, remainder, exp_r);
    check({tag, " div_by_zero"}, div_by_zero, exp_dz);
    check({tag, " busy_in_done"}, {busy, both_seen}, 2'b00);
    if (mode == 1) begin
      start = 1'b1;
      repeat (4) tick();
      check({tag, " hold_done"}, {done, busy, quotient, remainder}, {2'b10, exp_q, exp_r});
    end
    start = 1'b0;
    tick();
    check({tag, " back_to_idle"}, {done, busy, div_by_zero}, 3'b000);
  endtask

  initial begin
    logic [31:0] ra, rb;

    rst_n = 1'b0;
    start = 1'b1;
    data_in = '0;
    repeat (3) tick();
    check("reset_outputs", {quotient, remainder, busy, done, div_by_zero}, '0);

    rst_n = 1'b1;
    run_div(16'd69, 16'd9, "69/9", 0);
    run_div(16'd5, 16'd0, "5/0", 0);
    run_div(16'd3, 16'd9, "3/9", 0);
    run_div(16'd9, 16'd9, "9/9", 0);
    run_div(16'd0, 16'd7, "0/7", 0);
    run_div(16'd50, 16'd8, "50/8_hold", 1);
    run_div(16'd100, 16'd7, "100/7", 0);
    run_div(16'd45, 16'd4, "45/4_toggle", 2);
    run_div(16'hFFFF, 16'h8000, "FFFF/8000", 0);

    // Reset partway through a long subtraction run.
    start = 1'b1;
    tick();
    data_in = 16'd1000;
    start = 1'b0;
    tick();
    data_in = 16'd1;
    repeat (21) tick();
    check("mid_sub_busy", {busy, done}, 2'b10);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_sub_reset", {quotient, remainder, busy, done, div_by_zero}, '0);
    tick();
    check("after_reset_idle", {busy, done}, 2'b00);
    run_div(16'd20, 16'd6, "20/6", 0);

    for (int i = 0; i < 10; i++) begin
      rb = (i % 5 == 4) ? 32'd0 : $urandom_range(1, 65535);
      if (rb == 0) ra = $urandom_range(0, 65535);
      else ra = rb * $urandom_range(0, 300) + $urandom_range(0, rb - 1);
      if (ra > 32'd65535) ra = $urandom_range(0, 65535);
      run_div(ra[W-1:0], rb[W-1:0], $sformatf("rand%0d_%0d/%0d", i, ra, rb), i % 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
